// File: rtl/spi_tx_pkg.sv
// Shared types for the SPI track-packet transmitter: FSM state encoding and packet width helper.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } tx_state_e;

  function automatic int unsigned pkt_width(input int unsigned num_tracks,
                                            input int unsigned packet_size);
    return num_tracks * packet_size;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period down-counter: reload restarts a SCK_HALF_DIV-cycle interval, tick_c marks its last cycle.
module spi_tick_gen #(
  parameter int unsigned SCK_HALF_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(SCK_HALF_DIV + 1);
  localparam logic [CW-1:0] LOAD = CW'(SCK_HALF_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/spi_packet_tx.sv
// SPI master serializing one W-bit track packet per cs frame, MSB first.
// Optional SPI_TX_REPEAT_EN: resend the last packet after REFRESH_CYC idle cycles.
module spi_packet_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned NUM_TRACKS   = 1,
  parameter int unsigned PACKET_SIZE  = 24,
  parameter int unsigned SCK_HALF_DIV = 4,
  parameter int unsigned CS_GAP       = 2
`ifdef SPI_TX_REPEAT_EN
  , parameter int unsigned REFRESH_CYC = 2**20
`endif
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [pkt_width(NUM_TRACKS, PACKET_SIZE)-1:0] pkt_data,
  input  logic                                          pkt_valid,
  output logic                                          pkt_ready,
  output logic                                          cs,
  output logic                                          sck,
  output logic                                          sdo,
  output logic                                          done
);

  localparam int unsigned W  = pkt_width(NUM_TRACKS, PACKET_SIZE);
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned GW = $clog2(CS_GAP + 1);

  tx_state_e     state, state_nx;
  logic [W-1:0]  shreg, shreg_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic          cs_nx, sck_nx, sdo_nx, done_nx, ready_nx;
  logic          tick_c, accept_c, load_c;
  logic [W-1:0]  load_data_c;

  assign accept_c = pkt_ready && pkt_valid;

`ifdef SPI_TX_REPEAT_EN
  localparam int unsigned RW = $clog2(REFRESH_CYC + 1);

  logic [W-1:0]  last_pkt;
  logic          have_pkt;
  logic [RW-1:0] idle_cnt;
  logic          fire_c;

  // A fresh pkt_valid suppresses the refresh and restarts the idle count.
  assign fire_c      = (state == IDLE) && have_pkt && !pkt_valid && (idle_cnt == RW'(REFRESH_CYC - 1));
  assign load_c      = accept_c || fire_c;
  assign load_data_c = accept_c ? pkt_data : last_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pkt <= '0;
      have_pkt <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (accept_c) begin
        last_pkt <= pkt_data;
        have_pkt <= 1'b1;
      end
      if ((state == IDLE) && have_pkt && !pkt_valid && !fire_c) begin
        idle_cnt <= idle_cnt + RW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`else
  assign load_c      = accept_c;
  assign load_data_c = pkt_data;
`endif

  spi_tick_gen #(
    .SCK_HALF_DIV(SCK_HALF_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .reload(state_nx != state),
    .tick_c(tick_c)
  );

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    cs_nx      = cs;
    sck_nx     = sck;
    sdo_nx     = sdo;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (load_c) begin
          state_nx   = SETUP;
          shreg_nx   = load_data_c;
          bit_cnt_nx = BW'(W - 1);
          cs_nx      = 1'b1;
          sck_nx     = 1'b0;
          sdo_nx     = load_data_c[W-1];
        end
      end
      SETUP, LOW: begin
        if (tick_c) begin
          state_nx = HIGH;
          sck_nx   = 1'b1;
        end
      end
      HIGH: begin
        if (tick_c) begin
          sck_nx = 1'b0;
          if (bit_cnt == '0) begin
            state_nx = HOLD;
          end else begin
            state_nx   = LOW;
            shreg_nx   = shreg << 1;
            sdo_nx     = shreg_nx[W-1];
            bit_cnt_nx = bit_cnt - BW'(1);
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_nx   = GAP;
          cs_nx      = 1'b0;
          sdo_nx     = 1'b0;
          done_nx    = 1'b1;
          gap_cnt_nx = GW'(CS_GAP - 1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cs        <= 1'b0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      done      <= 1'b0;
      pkt_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      cs        <= cs_nx;
      sck       <= sck_nx;
      sdo       <= sdo_nx;
      done      <= done_nx;
      pkt_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_spi_packet_tx.sv
// Directed bench for spi_packet_tx: 1-track and 4-track instances, frames decoded on sck rising edges.
module tb_spi_packet_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1, v1 = 1'b0, r1, cs1, sck1, sdo1, done1;
  logic [23:0] d1 = '0;
  logic        rst4 = 1'b1, v4 = 1'b0, r4, cs4, sck4, sdo4, done4;
  logic [95:0] d4 = '0;

  int errors = 0;
  int checks = 0;

  spi_packet_tx #(
    .NUM_TRACKS(1), .PACKET_SIZE(24), .SCK_HALF_DIV(4), .CS_GAP(2)
`ifdef SPI_TX_REPEAT_EN
    , .REFRESH_CYC(64)
`endif
  ) dut1 (
    .clk(clk), .reset(rst1), .pkt_data(d1), .pkt_valid(v1), .pkt_ready(r1),
    .cs(cs1), .sck(sck1), .sdo(sdo1), .done(done1)
  );

  spi_packet_tx #(
    .NUM_TRACKS(4), .PACKET_SIZE(24), .SCK_HALF_DIV(4), .CS_GAP(2)
`ifdef SPI_TX_REPEAT_EN
    , .REFRESH_CYC(64)
`endif
  ) dut4 (
    .clk(clk), .reset(rst4), .pkt_data(d4), .pkt_valid(v4), .pkt_ready(r4),
    .cs(cs4), .sck(sck4), .sdo(sdo4), .done(done4)
  );

  // Frame decoders: shift sdo in on each sck rise, publish results when cs falls.
  logic [95:0] cur_w1 = '0, m1_word = '0, cur_w4 = '0, m4_word = '0;
  int cur_r1 = 0, cur_l1 = 0, m1_rises = 0, m1_cslen = 0, m1_frames = 0, m1_done = 0;
  int cur_r4 = 0, cur_l4 = 0, m4_rises = 0, m4_cslen = 0, m4_frames = 0, m4_done = 0;
  logic pcs1 = 1'b0, psck1 = 1'b0, pcs4 = 1'b0, psck4 = 1'b0;

  always @(negedge clk) begin
    if (rst1) begin
      cur_w1 = '0; cur_r1 = 0; cur_l1 = 0; pcs1 = 1'b0; psck1 = 1'b0;
    end else begin
      if (cs1) begin
        cur_l1++;
        if (sck1 && !psck1) begin cur_w1 = {cur_w1[94:0], sdo1}; cur_r1++; end
      end
      if (pcs1 && !cs1) begin
        m1_word = cur_w1; m1_rises = cur_r1; m1_cslen = cur_l1; m1_frames++;
        cur_w1 = '0; cur_r1 = 0; cur_l1 = 0;
      end
      if (done1) m1_done++;
      pcs1 = cs1; psck1 = sck1;
    end
  end

  always @(negedge clk) begin
    if (rst4) begin
      cur_w4 = '0; cur_r4 = 0; cur_l4 = 0; pcs4 = 1'b0; psck4 = 1'b0;
    end else begin
      if (cs4) begin
        cur_l4++;
        if (sck4 && !psck4) begin cur_w4 = {cur_w4[94:0], sdo4}; cur_r4++; end
      end
      if (pcs4 && !cs4) begin
        m4_word = cur_w4; m4_rises = cur_r4; m4_cslen = cur_l4; m4_frames++;
        cur_w4 = '0; cur_r4 = 0; cur_l4 = 0;
      end
      if (done4) m4_done++;
      pcs4 = cs4; psck4 = sck4;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_both();
    rst1 = 1'b1; rst4 = 1'b1; v1 = 1'b0; v4 = 1'b0;
    step(); step();
    rst1 = 1'b0; rst4 = 1'b0;
    step();
  endtask

  task automatic reset_dut1();
    rst1 = 1'b1; v1 = 1'b0;
    step(); step();
    rst1 = 1'b0;
    step();
  endtask

  // Offer one packet on dut1 (ready assumed high) and run until ready returns; lat = cycles after accept.
  task automatic send1(input logic [23:0] data, input logic [23:0] alt, input int change_at,
                       output int lat, output logic first_cs, output logic first_sdo);
    d1 = data; v1 = 1'b1;
    step();
    lat = 1; v1 = 1'b0; first_cs = cs1; first_sdo = sdo1;
    while (!r1 && lat < 2000) begin
      if (lat == change_at) d1 = alt;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    step(); step();
    checks++; if ({cs1, sck1, sdo1, done1} !== 4'b0000) begin errors++; $display("FAIL reset_outs: got %b expected 0000", {cs1, sck1, sdo1, done1}); end
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", r1); end
    checks++; if ({cs4, sck4, sdo4, done4, r4} !== 5'b00000) begin errors++; $display("FAIL reset_outs4: got %b expected 00000", {cs4, sck4, sdo4, done4, r4}); end
    rst1 = 1'b0; rst4 = 1'b0;
    step();
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", r1); end
    checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL ready_after_reset4: got %b expected 1", r4); end
  endtask

  task automatic test_single_frame();
    int lat, f0, dn0;
    logic fc, fs;
    reset_dut1();
    f0 = m1_frames; dn0 = m1_done;
    send1(24'h0114ff, 24'h0114ff, 0, lat, fc, fs);
    checks++; if (fc !== 1'b1 || fs !== 1'b0) begin errors++; $display("FAIL setup_cs_sdo: got cs=%b sdo=%b expected cs=1 sdo=0", fc, fs); end
    checks++; if (lat != 199) begin errors++; $display("FAIL accept_to_ready: got %0d expected 199", lat); end
    checks++; if (m1_frames != f0 + 1) begin errors++; $display("FAIL frame_count: got %0d expected %0d", m1_frames, f0 + 1); end
    checks++; if (m1_word[23:0] !== 24'h0114ff) begin errors++; $display("FAIL word_0114ff: got %h expected 0114ff", m1_word[23:0]); end
    checks++; if (m1_rises != 24) begin errors++; $display("FAIL sck_rises: got %0d expected 24", m1_rises); end
    checks++; if (m1_cslen != 196) begin errors++; $display("FAIL cs_high_len: got %0d expected 196", m1_cslen); end
    checks++; if (m1_done != dn0 + 1) begin errors++; $display("FAIL done_pulses: got %0d expected %0d", m1_done - dn0, 1); end
  endtask

  task automatic test_back_to_back();
    int f0, dn0, acc, gap, cyc, rises1, len1;
    logic pend, saved;
    logic [95:0] w1;
    reset_both();
    f0 = m4_frames; dn0 = m4_done; acc = 0; gap = 0; cyc = 0; pend = 1'b0; saved = 1'b0;
    w1 = '0; rises1 = 0; len1 = 0;
    d4 = 96'h0114ff0217ff0114ff0217ff; v4 = 1'b1;
    while (!(m4_frames == f0 + 2 && r4) && cyc < 4000) begin
      if (v4 && r4) pend = 1'b1;
      step(); cyc++;
      if (pend) begin
        acc++; pend = 1'b0;
        if (acc == 1) d4 = '0; else v4 = 1'b0;
      end
      if (m4_frames == f0 + 1 && !cs4 && !r4) gap++;
      if (m4_frames == f0 + 1 && !saved) begin
        w1 = m4_word; rises1 = m4_rises; len1 = m4_cslen; saved = 1'b1;
      end
    end
    v4 = 1'b0;
    checks++; if (acc != 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc); end
    checks++; if (w1 !== 96'h0114ff0217ff0114ff0217ff) begin errors++; $display("FAIL b2b_word1: got %h expected 0114ff0217ff0114ff0217ff", w1); end
    checks++; if (rises1 != 96 || len1 != 772) begin errors++; $display("FAIL b2b_frame1_shape: got rises=%0d cs=%0d expected 96/772", rises1, len1); end
    checks++; if (m4_frames != f0 + 2 || m4_word !== 96'h0) begin errors++; $display("FAIL b2b_word2: got frames=%0d word=%h expected %0d/0", m4_frames - f0, m4_word, 2); end
    checks++; if (m4_rises != 96) begin errors++; $display("FAIL b2b_rises2: got %0d expected 96", m4_rises); end
    checks++; if (gap != 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", gap); end
    checks++; if (m4_done != dn0 + 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", m4_done - dn0); end
    rst4 = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int f0, dn0, rises, cyc, lat;
    logic prev, fc, fs;
    reset_dut1();
    f0 = m1_frames; dn0 = m1_done; rises = 0; cyc = 0; prev = 1'b0;
    d1 = 24'h0114ff; v1 = 1'b1;
    step(); v1 = 1'b0;
    while (rises < 10 && cyc < 2000) begin
      step(); cyc++;
      if (sck1 && !prev) rises++;
      prev = sck1;
    end
    checks++; if (rises != 10 || cs1 !== 1'b1) begin errors++; $display("FAIL abort_reach_rise10: got rises=%0d cs=%b expected 10/1", rises, cs1); end
    rst1 = 1'b1;
    step();
    checks++; if ({cs1, sck1, sdo1, done1, r1} !== 5'b00000) begin errors++; $display("FAIL abort_outs: got %b expected 00000", {cs1, sck1, sdo1, done1, r1}); end
    step();
    rst1 = 1'b0;
    step();
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", r1); end
    checks++; if (m1_frames != f0 || m1_done != dn0) begin errors++; $display("FAIL abort_no_done: got frames+%0d done+%0d expected 0/0", m1_frames - f0, m1_done - dn0); end
    send1(24'hABCDEF, 24'hABCDEF, 0, lat, fc, fs);
    checks++; if (m1_word[23:0] !== 24'hABCDEF || m1_rises != 24) begin errors++; $display("FAIL abort_next_word: got %h rises=%0d expected abcdef/24", m1_word[23:0], m1_rises); end
    checks++; if (lat != 199 || m1_done != dn0 + 1) begin errors++; $display("FAIL abort_next_timing: got lat=%0d done+%0d expected 199/1", lat, m1_done - dn0); end
  endtask

  task automatic test_data_change();
    int lat;
    logic fc, fs;
    reset_dut1();
    send1(24'h5A3C96, 24'hFFFFFF, 40, lat, fc, fs);
    checks++; if (m1_word[23:0] !== 24'h5A3C96 || lat != 199) begin errors++; $display("FAIL latched_mid: got %h lat=%0d expected 5a3c96/199", m1_word[23:0], lat); end
    send1(24'hC3A5F0, 24'h000000, 1, lat, fc, fs);
    checks++; if (m1_word[23:0] !== 24'hC3A5F0 || fs !== 1'b1) begin errors++; $display("FAIL latched_early: got %h sdo0=%b expected c3a5f0/1", m1_word[23:0], fs); end
  endtask

`ifdef SPI_TX_REPEAT_EN
  task automatic test_repeat();
    int lat, f0, dn0, idle, cyc, csh;
    logic fc, fs;
    reset_dut1();
    csh = 0;
    for (int i = 0; i < 100; i++) begin step(); if (cs1) csh++; end
    checks++; if (csh != 0) begin errors++; $display("FAIL no_resend_before_first: got %0d cs cycles expected 0", csh); end
    send1(24'h0114ff, 24'h0114ff, 0, lat, fc, fs);
    f0 = m1_frames; dn0 = m1_done; idle = 0; cyc = 0;
    while (r1 && cyc < 500) begin idle++; step(); cyc++; end
    checks++; if (idle != 64 || cs1 !== 1'b1) begin errors++; $display("FAIL refresh_delay: got idle=%0d cs=%b expected 64/1", idle, cs1); end
    while (!r1 && cyc < 2000) begin step(); cyc++; end
    checks++; if (m1_frames != f0 + 1 || m1_word[23:0] !== 24'h0114ff) begin errors++; $display("FAIL refresh_word: got frames+%0d word=%h expected 1/0114ff", m1_frames - f0, m1_word[23:0]); end
    checks++; if (m1_rises != 24 || m1_cslen != 196 || m1_done != dn0 + 1) begin errors++; $display("FAIL refresh_shape: got rises=%0d cs=%0d done+%0d expected 24/196/1", m1_rises, m1_cslen, m1_done - dn0); end
  endtask
`else
  task automatic test_repeat();
    int lat, f0, csh;
    logic fc, fs;
    reset_dut1();
    send1(24'h0114ff, 24'h0114ff, 0, lat, fc, fs);
    f0 = m1_frames; csh = 0;
    for (int i = 0; i < 150; i++) begin step(); if (cs1 || !r1) csh++; end
    checks++; if (csh != 0 || m1_frames != f0) begin errors++; $display("FAIL stays_idle: got busy=%0d frames+%0d expected 0/0", csh, m1_frames - f0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
